// File: rtl/afe_self_trigger.sv
// Per-channel self trigger on the 5 AFE x 9 slot x 16-bit filtered bus.
// Stage 1 registers the 40 data samples; stage 2 runs one IDLE/RUN/HOLD FSM per channel.
module afe_self_trigger #(
  parameter int unsigned HOLDOFF   = 64,
  parameter int unsigned MIN_ABOVE = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [15:0]  threshold,
  input  logic [39:0]  ch_mask,
  input  logic         count_clr,
  input  logic [719:0] x,
  output logic [39:0]  trig,
  output logic         trig_any,
  output logic [31:0]  trig_count
);

  localparam int NUM_AFE  = 5;
  localparam int NUM_CH   = 8;
  localparam int NUM_SLOT = 9;
  localparam int SW       = 16;
  localparam int NUM_CHAN = NUM_AFE * NUM_CH;

  localparam logic [3:0]  RUN_TARGET = 4'(MIN_ABOVE);
  localparam logic [15:0] HOLD_INIT  = 16'(HOLDOFF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Assertion is asynchronous; release is delayed two clk edges so every flop leaves reset together.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic [NUM_CHAN*SW-1:0] x_data;
  logic [NUM_AFE*SW-1:0]  unused_frame;

  for (genvar a = 0; a < NUM_AFE; a++) begin : g_afe
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign x_data[(a*NUM_CH+c)*SW +: SW] = x[(a*NUM_SLOT+c)*SW +: SW];
    end
    // Slot 8 is the pass-through frame slot and never feeds a channel.
    assign unused_frame[a*SW +: SW] = x[(a*NUM_SLOT+8)*SW +: SW];
  end

  logic [NUM_CHAN*SW-1:0] sample_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sample_q <= '0;
    else        sample_q <= x_data;
  end

  logic [NUM_CHAN-1:0] above;

  always_comb begin
    above = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      above[i] = $signed(sample_q[i*SW +: SW]) > $signed(threshold);
    end
  end

  state_t              state_q [NUM_CHAN];
  state_t              state_d [NUM_CHAN];
  logic [3:0]          run_q   [NUM_CHAN];
  logic [3:0]          run_d   [NUM_CHAN];
  logic [15:0]         hold_q  [NUM_CHAN];
  logic [15:0]         hold_d  [NUM_CHAN];
  logic [NUM_CHAN-1:0] fire;

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    logic go;
    go   = 1'b0;
    fire = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      state_d[i] = state_q[i];
      run_d[i]   = run_q[i];
      hold_d[i]  = hold_q[i];
      go         = 1'b0;
      if (!en || !ch_mask[i]) begin
        state_d[i] = IDLE;
        run_d[i]   = '0;
        hold_d[i]  = '0;
      end else begin
        unique case (state_q[i])
          IDLE: begin
            if (above[i]) begin
              run_d[i] = 4'd1;
              if (RUN_TARGET == 4'd1) go = 1'b1;
              else                    state_d[i] = RUN;
            end
          end
          RUN: begin
            if (above[i]) begin
              run_d[i] = run_q[i] + 4'd1;
              if (run_q[i] + 4'd1 == RUN_TARGET) go = 1'b1;
            end else begin
              state_d[i] = IDLE;
              run_d[i]   = '0;
            end
          end
          HOLD: begin
            // Re-arming needs the signal back at or below threshold once the holdoff has run out.
            if (hold_q[i] != '0) hold_d[i] = hold_q[i] - 16'd1;
            else if (!above[i])  state_d[i] = IDLE;
          end
          default: begin
            state_d[i] = IDLE;
            run_d[i]   = '0;
            hold_d[i]  = '0;
          end
        endcase
        if (go) begin
          state_d[i] = HOLD;
          run_d[i]   = '0;
          hold_d[i]  = HOLD_INIT;
        end
      end
      fire[i] = go;
    end
  end

  // NOTE: these are per-channel registers, not a RAM, so they are reset like any other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        state_q[i] <= IDLE;
        run_q[i]   <= '0;
        hold_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig     <= '0;
      trig_any <= 1'b0;
    end else begin
      trig     <= fire;
      trig_any <= |fire;
    end
  end

  logic [31:0] count_q;

  // Clear wins over increment; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            count_q <= '0;
    else if (count_clr)                    count_q <= '0;
    else if (trig_any && count_q != '1)    count_q <= count_q + 32'd1;
  end

  assign trig_count = count_q;

endmodule

// File: tb/tb_afe_self_trigger.sv
// Directed bench for afe_self_trigger: stimulus pushes expected pulses, a negedge monitor pops and checks.
module tb_afe_self_trigger;

  localparam int HOLDOFF   = 64;
  localparam int MIN_ABOVE = 2;

  logic         clk;
  logic         reset_n;
  logic         en;
  logic [15:0]  threshold;
  logic [39:0]  ch_mask;
  logic         count_clr;
  logic [719:0] x;
  logic [39:0]  trig;
  logic         trig_any;
  logic [31:0]  trig_count;

  afe_self_trigger #(.HOLDOFF(HOLDOFF), .MIN_ABOVE(MIN_ABOVE)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .threshold  (threshold),
    .ch_mask    (ch_mask),
    .count_clr  (count_clr),
    .x          (x),
    .trig       (trig),
    .trig_any   (trig_any),
    .trig_count (trig_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [39:0] bits;
    int          at;
    logic [31:0] count;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_count = '0;
  int          n_checks  = 0;
  int          n_errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  function automatic logic [39:0] onehot(input int a, input int c);
    logic [39:0] v;
    v = '0;
    v[a*8+c] = 1'b1;
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(input int a, input int c, input logic [15:0] v);
    x[(a*9+c)*16 +: 16] = v;
  endtask

  // Called on the cycle the MIN_ABOVE-th sample is driven: pulse shows two cycles later.
  task automatic expect_pulse(input logic [39:0] bits, input bit clr);
    exp_t e;
    exp_count = clr ? 32'd0 : sat_inc(exp_count);
    e.bits  = bits;
    e.at    = cyc + 2;
    e.count = exp_count;
    sb.push_back(e);
  endtask

  task automatic fire_pair(input int a, input int c, input logic [15:0] v, input bit clr);
    set_ch(a, c, v);
    step(1);
    expect_pulse(onehot(a, c), clr);
    step(1);
    set_ch(a, c, 16'd0);
  endtask

  bit          cnt_pending = 1'b0;
  logic [31:0] cnt_exp     = '0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (cnt_pending) begin
      check("count_after_pulse", 64'(trig_count), 64'(cnt_exp));
      cnt_pending = 1'b0;
    end
    if (trig_any) begin
      if (sb.size() == 0) begin
        check("unexpected_trig", 64'(trig), 64'd0);
      end else begin
        e = sb.pop_front();
        check("trig_bits", 64'(trig), 64'(e.bits));
        check("trig_cycle", 64'(cyc), 64'(e.at));
        cnt_exp     = e.count;
        cnt_pending = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n   = 1'b1;
    en        = 1'b1;
    threshold = 16'd100;
    ch_mask   = '1;
    count_clr = 1'b0;
    x         = '0;
    #2 reset_n = 1'b0;
    step(2);
    check("reset_trig", 64'(trig), 64'd0);
    check("reset_trig_any", 64'(trig_any), 64'd0);
    check("reset_count", 64'(trig_count), 64'd0);
    reset_n = 1'b1;
    step(4);
    check("post_reset_count", 64'(trig_count), 64'd0);

    // 1: two samples just above threshold on AFE0 ch0
    fire_pair(0, 0, 16'd101, 1'b0);
    step(4);
    count_clr = 1'b1;
    step(1);
    count_clr = 1'b0;
    exp_count = '0;
    check("count_clr", 64'(trig_count), 64'd0);

    // 2: broken run, large negative, and sample equal to threshold: none may fire
    set_ch(2, 3, 16'd150); set_ch(2, 4, 16'h8000); set_ch(2, 5, 16'd100);
    step(1);
    set_ch(2, 3, 16'd50);
    step(1);
    set_ch(2, 3, 16'd150);
    step(1);
    set_ch(2, 3, 16'd0); set_ch(2, 4, 16'd0); set_ch(2, 5, 16'd0);
    step(6);
    check("no_trig_count", 64'(trig_count), 64'd0);

    // 3: long high level fires once; re-arm only after dropping once holdoff has expired
    set_ch(4, 7, 16'd200);
    step(1);
    expect_pulse(onehot(4, 7), 1'b0);
    step(199);
    set_ch(4, 7, 16'd0);
    step(1);
    set_ch(4, 7, 16'd200);
    step(1);
    expect_pulse(onehot(4, 7), 1'b0);
    step(18);
    set_ch(4, 7, 16'd0);
    step(1);
    set_ch(4, 7, 16'd200);
    step(80);
    set_ch(4, 7, 16'd0);
    step(80);

    // 4: frame slots at full scale are ignored; then every channel crosses together
    for (int a = 0; a < 5; a++) set_ch(a, 8, 16'h7FFF);
    step(5);
    for (int a = 0; a < 5; a++) for (int c = 0; c < 8; c++) set_ch(a, c, 16'd120);
    step(1);
    expect_pulse('1, 1'b0);
    step(1);
    for (int a = 0; a < 5; a++) for (int c = 0; c < 8; c++) set_ch(a, c, 16'd0);
    step(80);
    for (int a = 0; a < 5; a++) set_ch(a, 8, 16'd0);

    // 5: clear coincident with a pulse, then saturation from a preloaded count
    fire_pair(1, 2, 16'd150, 1'b1);
    step(1);
    count_clr = 1'b1;
    step(1);
    count_clr = 1'b0;
    step(3);
    force dut.count_q = 32'hFFFF_FFFE;
    #1 release dut.count_q;
    exp_count = 32'hFFFF_FFFE;
    check("count_preload", 64'(trig_count), 64'h0000_0000_FFFF_FFFE);
    step(1);
    fire_pair(3, 0, 16'd150, 1'b0);
    step(5);
    fire_pair(3, 1, 16'd150, 1'b0);
    step(5);

    // 6: masked channel, en dropped mid-run, reset pulse mid-holdoff
    ch_mask[2] = 1'b0;
    set_ch(0, 2, 16'd150);
    step(4);
    set_ch(0, 2, 16'd0);
    step(3);
    ch_mask[2] = 1'b1;

    set_ch(0, 1, 16'd150);
    step(2);
    en = 1'b0;
    step(4);
    en = 1'b1;
    expect_pulse(onehot(0, 1), 1'b0);
    step(3);
    set_ch(0, 1, 16'd0);
    step(3);

    fire_pair(1, 5, 16'd150, 1'b0);
    step(10);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_count", 64'(trig_count), 64'd0);
    check("async_reset_trig", 64'(trig), 64'd0);
    check("async_reset_trig_any", 64'(trig_any), 64'd0);
    reset_n   = 1'b1;
    exp_count = '0;
    step(6);
    fire_pair(1, 5, 16'd150, 1'b0);
    step(5);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
